nibble_serial_addsub: RTL and testbench

- Parametrised successor to the single-nibble adder.
- Adds or subtracts two WIDTH-bit operands one 4-bit nibble per clock, LSB nibble first, with the carry held in a register between nibbles.
- Provides a start/busy/done handshake and a held result, so one small adder serves wide operands in the HW datapath exercises.

---
 rtl/nibble_serial_addsub_pkg.sv | 5 +
 rtl/nibble_add4.sv | 14 +
 rtl/nibble_serial_addsub.sv | 71 +++++++
 tb/tb_nibble_serial_addsub.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// nibble_serial_addsub_pkg: shared state encoding and nibble width for the serial adder
package nibble_serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NIB_W = 4;
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: 4-bit adder exposing the carry into bit 3 for signed overflow detection
module nibble_add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);
  logic [3:0] lo;
  assign lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b0, cin};
  assign c3 = lo[3];
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {4'b0, cin};
endmodule

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/subtract computed one nibble per clock, LSB first
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int NNIB  = WIDTH / NIB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = NNIB > 1 ? $clog2(NNIB) : 1;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last, accept;
  logic [3:0]       s;
  logic             c, c3;
  nibble_add4 u_add (
    .x    (a_q[NIB_W*int'(cnt) +: NIB_W]),
    .y    (b_q[NIB_W*int'(cnt) +: NIB_W]),
    .cin  (carry),
    .s    (s),
    .cout (c),
    .c3   (c3)
  );
  assign last   = cnt == CW'(NNIB - 1);
  assign accept = start && state != RUN;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  always_comb begin
    state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        sum[NIB_W*int'(cnt) +: NIB_W] <= s;
        carry <= c;
        cnt   <= cnt + 1'b1;
        if (last) begin
          cout <= c;
          ovf  <= c ^ c3;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb_nibble_serial_addsub: directed vectors checked against a cycle-level arithmetic model
module tb_nibble_serial_addsub;
  logic clk = 0, rst_n, start, sub;
  logic [7:0] a, b, sum;
  logic busy, done, cout, ovf;
  logic start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic start4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));
  nibble_serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .sub(sub16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));
  nibble_serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // returns {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [8:0] r;
    logic o;
    r = s ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    o = s ? (x[7] != y[7]) && (r[7] != x[7]) : (x[7] == y[7]) && (r[7] != x[7]);
    return {o, s ? (x >= y) : r[8], r[7:0]};
  endfunction

  logic e_busy, e_done, e_cout, e_ovf;
  logic [7:0] e_sum;
  logic [9:0] pend;
  int left;
  always @(posedge clk) begin
    if (!rst_n) begin
      {e_busy, e_done, e_cout, e_ovf, e_sum} = '0;
      left = 0;
    end else if (left > 0) begin
      left--;
      e_busy = left > 0;
      e_done = left == 0;
      if (left == 0) {e_ovf, e_cout, e_sum} = pend;
    end else if (start) begin
      pend = ref_op(a, b, sub);
      left = 2;
      e_busy = 1;
      e_done = 0;
    end else begin
      e_busy = 0;
      e_done = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    if (!e_busy) begin
      chk("sum", sum, e_sum);
      chk("cout", cout, e_cout);
      chk("ovf", ovf, e_ovf);
    end
  end

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo);
    int nb = 0;
    logic seen = 0;
    @(negedge clk) begin a = x; b = y; sub = s; start = 1; end
    @(negedge clk) start = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("op_done_seen", seen, 1);
    chk("op_busy_cycles", nb, 2);
    chk("op_sum", sum, es);
    chk("op_cout", cout, ec);
    chk("op_ovf", ovf, eo);
  endtask

  initial begin
    int nd, nb;
    logic seen;
    rst_n = 0; start = 1; a = 8'h55; b = 8'h33; sub = 0;
    start16 = 0; a16 = 0; b16 = 0; sub16 = 0; start4 = 0; a4 = 0; b4 = 0; sub4 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 8'h00);
    rst_n = 1; start = 0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", busy, 0);
    run_op(8'h24, 8'h81, 0, 8'hA5, 0, 0);
    run_op(8'hFF, 8'hFF, 0, 8'hFE, 1, 0);
    run_op(8'h76, 8'h3D, 0, 8'hB3, 0, 1);
    run_op(8'h76, 8'h3D, 1, 8'h39, 1, 0);
    run_op(8'h12, 8'h8F, 1, 8'h83, 0, 1);
    // second start during busy must be ignored
    @(negedge clk) begin a = 8'h10; b = 8'h05; sub = 0; start = 1; end
    @(negedge clk) begin a = 8'hF0; b = 8'h0F; sub = 1; start = 1; end
    @(negedge clk) start = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("ign_done_seen", seen, 1);
    chk("ign_sum", sum, 8'h15);
    repeat (3) @(negedge clk);
    chk("ign_no_second", busy, 0);
    // held start: one result every three cycles
    @(negedge clk) begin a = 8'h11; b = 8'h22; sub = 0; start = 1; end
    nd = 0;
    repeat (9) begin
      @(negedge clk);
      if (done) nd++;
    end
    start = 0;
    chk("held_done_count", nd, 3);
    chk("held_sum", sum, 8'h33);
    repeat (3) @(negedge clk);
    // reset on the first RUN cycle
    @(negedge clk) begin a = 8'h01; b = 8'h02; start = 1; end
    @(negedge clk) begin start = 0; rst_n = 0; end
    @(negedge clk) rst_n = 1;
    chk("midrst_sum", sum, 8'h00);
    chk("midrst_busy", busy, 0);
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    // WIDTH=16
    @(negedge clk) begin a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 0; start16 = 1; end
    @(negedge clk) start16 = 0;
    nb = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (busy16) nb++;
      if (done16) seen = 1;
      else @(negedge clk);
    end
    chk("w16_done_seen", seen, 1);
    chk("w16_busy_cycles", nb, 4);
    chk("w16_sum", sum16, 16'h0000);
    chk("w16_cout", cout16, 1);
    chk("w16_ovf", ovf16, 0);
    // WIDTH=4
    @(negedge clk) begin a4 = 4'h9; b4 = 4'h8; sub4 = 0; start4 = 1; end
    @(negedge clk) start4 = 0;
    nb = 0; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (busy4) nb++;
      if (done4) seen = 1;
      else @(negedge clk);
    end
    chk("w4_done_seen", seen, 1);
    chk("w4_busy_cycles", nb, 1);
    chk("w4_sum", sum4, 4'h1);
    chk("w4_cout", cout4, 1);
    chk("w4_ovf", ovf4, 1);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
